seq_datapath: RTL and testbench
===============================

Name: seq_datapath

Overview:
- Parametrised successor to the Mini SRC bus datapath: WIDTH-bit datapath, NREGS-entry register file, Y/Z/HI/LO/MAR/MDR/IR/PC, plus an internal control-step sequencer.
- Fetches, decodes and executes 3-operand instructions autonomously over a req/ack memory port, instead of being driven by external control strobes.
- Sits between the memory subsystem and the future top-level CPU wrapper.

Parameters:
- WIDTH, 32, datapath and memory word width. Constraint: WIDTH >= 5+3*RSEL_W+4.
- NREGS, 16, register count; power of two, >= 4. Local RSEL_W = log2(NREGS).
- RESET_PC, 0, PC value after reset.

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  asynchronous, active-low reset.
- run  in  1  when low, the sequencer holds in FETCH without issuing mem_req.
- mem_req  out  1  memory request, held until acked.
- mem_we  out  1  1=write, 0=read; valid while mem_req is high.
- mem_addr  out  WIDTH  driven from MAR.
- mem_wdata  out  WIDTH  store data.
- mem_ack  in  1  transaction completes at an edge where mem_req&mem_ack.
- mem_rdata  in  WIDTH  sampled at the ack edge.
- dbg_sel  in  RSEL_W  register select for the debug port.
- dbg_data  out  WIDTH  combinational R[dbg_sel].
- pc_out  out  WIDTH  current PC.
- halted  out  1  high in HALT state.
- err  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (Clear low, asynchronous), effective immediately:
  - PC=RESET_PC.
  - All R, Y, Z, HI, LO, MAR, MDR, IR = 0.
  - State = FETCH; mem_req=0, mem_we=0, halted=0, err=0.
- Reset mid-transaction abandons the request; mem_req drops asynchronously.
- Instruction fields:
  - op = [WIDTH-1:WIDTH-5]
  - ra = next RSEL_W bits down
  - rb = next RSEL_W bits
  - rc = next RSEL_W bits
  - imm = low IMM_W = WIDTH-5-2*RSEL_W bits, sign-extended
  - For 32/16: op[31:27] ra[26:23] rb[22:19] rc[18:15] imm[18:0].
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 NEG (0-Rc), 7 NOT (~Rc)
  - 8 ADDI, 9 LD, 10 ST
  - 11 MUL (signed, 2*WIDTH product to HI:LO), 12 MFHI, 13 MFLO
  - 14 HALT; 15..31 illegal.
- Shift amount = Rc[log2(WIDTH)-1:0]. Shifts by >= WIDTH cannot occur.
- Arithmetic is modulo 2^WIDTH; no flags.
- Base addressing: for ADDI/LD/ST, rb==0 reads as zero. Elsewhere R0 reads its stored value. Writes to R0 are permitted.
- States:
  - FETCH: if run, MAR=PC, mem_req=1, mem_we=0. On ack: MDR<=mem_rdata, PC<=PC+1, go DECODE. No ack: stay, req held.
  - DECODE: IR<=MDR. HALT -> HALT state. Illegal -> err<=1, go HALT. Else -> T3.
  - T3: Y<=R[rb] (zero per base rule).
  - T4: Z<=ALU(Y, R[rc] or imm). ADDI/LD/ST use Y+imm. MUL uses Y*R[rc]. MFHI/MFLO do no ALU work.
  - T5:
    - ALU ops/ADDI: R[ra]<=Zlo, go FETCH.
    - MUL: HI<=Zhi, LO<=Zlo.
    - MFHI/MFLO: R[ra]<=HI/LO.
    - LD/ST: MAR<=Zlo, go MEM.
  - MEM: mem_req=1, mem_we=(ST), mem_wdata=R[ra]. On ack: LD MDR<=mem_rdata -> WB; ST -> FETCH.
  - WB: R[ra]<=MDR -> FETCH.
  - HALT: halted=1; exits only on reset.
- mem_req deasserts in the cycle after the ack edge (state change). mem_addr/mem_we/mem_wdata stay stable while req is high.
- Latency with zero-wait memory (ack with req):
  - ALU/ADDI/MUL/MF*: 5 cycles.
  - ST: 6 cycles.
  - LD: 7 cycles.
  - HALT: 2 cycles to halted=1.
  - Each wait cycle adds 1.
- run sampled only in FETCH before req is issued. Once req is high it completes regardless of run.
- ra==rb or ra==rc: reads use pre-write values; the write lands in T5/WB.
- PC wraps at 2^WIDTH.

Test Plan:
- Reset/idle: Clear low mid-FETCH with req high -> mem_req=0 immediately. After release, run=0 -> mem_req stays 0 and pc_out=RESET_PC=0.
- ADDI/ADD, zero-wait memory returns 0x40800005 (ADDI R1,R0,5), 0x41000007 (ADDI R2,R0,7), 0x01890000 (ADD R3,R1,R2):
  - dbg R3=12 after 15 cycles.
  - pc_out=3.
- MUL/MF: R1=0xFFFFFFFE, R2=3, then 0x58090000 (MUL R1,R2), then MFHI R4 / MFLO R5 -> R4=0xFFFFFFFF, R5=0xFFFFFFFA.
- LD/ST with 2-cycle ack delay: ST R3,0x10(R0) -> write addr 0x10 data 12. Then LD R6,0x10(R0) -> R6=12; LD takes 9 cycles.
- Base rule: R0=9, ADDI R7,R0,1 -> R7=1. ADD R8,R0,R0 -> R8=18.
- HALT/illegal: 0x70000000 -> halted=1, err=0, no further mem_req. Opcode 31 -> halted=1 and err=1; both cleared only by Clear.

Source files
------------

// File: rtl/seq_datapath.sv
// Self-sequencing Mini SRC style datapath: fetches, decodes and executes
// 3-operand instructions over a req/ack memory port.
module seq_datapath #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      NREGS    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     Clock,
  input  logic                     Clear,
  input  logic                     run,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic                     mem_ack,
  input  logic [WIDTH-1:0]         mem_rdata,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [WIDTH-1:0]         dbg_data,
  output logic [WIDTH-1:0]         pc_out,
  output logic                     halted,
  output logic                     err
);
  localparam int unsigned RSEL_W = $clog2(NREGS);
  localparam int unsigned SH_W   = $clog2(WIDTH);
  localparam int unsigned IMM_W  = WIDTH - 5 - 2*RSEL_W;
  localparam int unsigned RA_LSB = WIDTH - 5 - RSEL_W;
  localparam int unsigned RB_LSB = RA_LSB - RSEL_W;
  localparam int unsigned RC_LSB = RB_LSB - RSEL_W;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3,  OP_SHL  = 5'd4,  OP_SHR  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6,  OP_NOT  = 5'd7,  OP_ADDI = 5'd8;
  localparam logic [4:0] OP_LD   = 5'd9,  OP_ST   = 5'd10, OP_MUL  = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd12, OP_MFLO = 5'd13, OP_HALT = 5'd14;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_T3, S_T4, S_T5, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   regs [NREGS];
  logic [WIDTH-1:0]   pc, mar, mdr, ir, y, hi, lo;
  logic [2*WIDTH-1:0] z, alu_res;
  logic               req_hold;
  logic               fetch_done, mem_done;
  logic [4:0]         op, mdr_op;
  logic [RSEL_W-1:0]  ra, rb, rc;
  logic [WIDTH-1:0]   imm, rb_val, rc_val;
  logic               base_op;
  logic signed [2*WIDTH-1:0] y_ext, rc_ext;

  assign op     = ir[WIDTH-1 -: 5];
  assign mdr_op = mdr[WIDTH-1 -: 5];
  assign ra     = ir[RA_LSB +: RSEL_W];
  assign rb     = ir[RB_LSB +: RSEL_W];
  assign rc     = ir[RC_LSB +: RSEL_W];
  assign imm    = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  // Address-forming ops treat rb==0 as a zero base
  assign base_op = (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
  assign rb_val  = (base_op && rb == '0) ? '0 : regs[rb];
  assign rc_val  = regs[rc];
  assign y_ext   = {{WIDTH{y[WIDTH-1]}}, y};
  assign rc_ext  = {{WIDTH{rc_val[WIDTH-1]}}, rc_val};

  assign dbg_data  = regs[dbg_sel];
  assign pc_out    = pc;
  assign halted    = (state_q == S_HALT);
  assign mem_addr  = (state_q == S_FETCH) ? pc : mar;
  assign mem_wdata = regs[ra];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res[WIDTH-1:0] = y + rc_val;
      OP_SUB:  alu_res[WIDTH-1:0] = y - rc_val;
      OP_AND:  alu_res[WIDTH-1:0] = y & rc_val;
      OP_OR:   alu_res[WIDTH-1:0] = y | rc_val;
      OP_SHL:  alu_res[WIDTH-1:0] = y << rc_val[SH_W-1:0];
      OP_SHR:  alu_res[WIDTH-1:0] = y >> rc_val[SH_W-1:0];
      OP_NEG:  alu_res[WIDTH-1:0] = WIDTH'(0) - rc_val;
      OP_NOT:  alu_res[WIDTH-1:0] = ~rc_val;
      OP_ADDI, OP_LD, OP_ST: alu_res[WIDTH-1:0] = y + imm;
      OP_MUL:  alu_res = (2*WIDTH)'(y_ext * rc_ext);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Fetch request is gated by Clear so it drops the moment reset asserts
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    fetch_done = 1'b0;
    mem_done   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = (run | req_hold) & Clear;
        fetch_done = mem_req & mem_ack;
        if (fetch_done) state_d = S_DECODE;
      end
      S_DECODE: state_d = (mdr_op >= OP_HALT) ? S_HALT : S_T3;
      S_T3:     state_d = S_T4;
      S_T4:     state_d = S_T5;
      S_T5:     state_d = (op == OP_LD || op == OP_ST) ? S_MEM : S_FETCH;
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_ST);
        mem_done = mem_ack;
        if (mem_ack) state_d = (op == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc       <= RESET_PC;
      mar      <= '0;
      mdr      <= '0;
      ir       <= '0;
      y        <= '0;
      z        <= '0;
      hi       <= '0;
      lo       <= '0;
      req_hold <= 1'b0;
      err      <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          req_hold <= mem_req & ~mem_ack;
          if (mem_req) mar <= pc;
          if (fetch_done) begin
            mdr <= mem_rdata;
            pc  <= pc + WIDTH'(1);
          end
        end
        S_DECODE: begin
          ir <= mdr;
          if (mdr_op > OP_HALT) err <= 1'b1;
        end
        S_T3: y <= rb_val;
        S_T4: if (op != OP_MFHI && op != OP_MFLO) z <= alu_res;
        S_T5: begin
          case (op)
            OP_MUL: begin
              hi <= z[2*WIDTH-1:WIDTH];
              lo <= z[WIDTH-1:0];
            end
            OP_MFHI:      regs[ra] <= hi;
            OP_MFLO:      regs[ra] <= lo;
            OP_LD, OP_ST: mar <= z[WIDTH-1:0];
            default:      regs[ra] <= z[WIDTH-1:0];
          endcase
        end
        S_MEM: if (mem_done && op == OP_LD) mdr <= mem_rdata;
        S_WB:  regs[ra] <= mdr;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath: a 16-word program plus a one-word illegal
// program, served by a req/ack memory model with programmable wait states.
module tb_seq_datapath;
  logic        Clock = 1'b0;
  logic        Clear, run, mem_req, mem_we, mem_ack, halted, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_data, pc_out;
  logic [3:0]  dbg_sel;

  logic [31:0] prog [16];
  logic [31:0] dmem [16];
  int          ack_wait = 0;
  int          wcnt = 0, cyc = 0, req_cyc = 0, wr_cnt = 0, req_snap = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  int          pc_cyc [32];
  logic [31:0] last_pc = '0;
  int          checks = 0, fails = 0;

  seq_datapath #(.WIDTH(32), .NREGS(16), .RESET_PC(32'h0)) dut (
    .Clock(Clock), .Clear(Clear), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc_out(pc_out),
    .halted(halted), .err(err)
  );

  always #10 Clock = ~Clock;

  // Memory: program below 0x10, data from 0x10; ack after ack_wait wait cycles
  assign mem_ack   = mem_req && (wcnt >= ack_wait);
  assign mem_rdata = (mem_addr < 32'd16) ? prog[mem_addr[3:0]] : dmem[mem_addr[3:0]];

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (mem_req) req_cyc <= req_cyc + 1;
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
    if (mem_req && mem_ack && mem_we) begin
      dmem[mem_addr[3:0]] <= mem_wdata;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  // Cycle stamp of every PC change, i.e. of every fetch acceptance
  always @(negedge Clock) begin
    if (pc_out !== last_pc) begin
      pc_cyc[pc_out[4:0]] = cyc;
      last_pc = pc_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] sel, input logic [31:0] exp);
    dbg_sel = sel;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic wait_pc(input logic [31:0] target, input int bound);
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (pc_out !== target && n < bound);
    check($sformatf("wait_pc_%0d", target), pc_out, target);
    #1;
  endtask

  initial begin
    Clear = 1'b1; run = 1'b0; dbg_sel = 4'd0;
    for (int i = 0; i < 16; i++) begin prog[i] = '0; dmem[i] = '0; end
    for (int i = 0; i < 32; i++) pc_cyc[i] = 0;
    prog[0]  = 32'h4080_0005;  // ADDI R1,R0,5
    prog[1]  = 32'h4100_0007;  // ADDI R2,R0,7
    prog[2]  = 32'h0189_0000;  // ADD  R3,R1,R2
    prog[3]  = 32'h4087_FFFE;  // ADDI R1,R0,-2
    prog[4]  = 32'h4100_0003;  // ADDI R2,R0,3
    prog[5]  = 32'h5809_0000;  // MUL  R1,R2
    prog[6]  = 32'h6200_0000;  // MFHI R4
    prog[7]  = 32'h6A80_0000;  // MFLO R5
    prog[8]  = 32'h5180_0010;  // ST   R3,0x10(R0)
    prog[9]  = 32'h4B00_0010;  // LD   R6,0x10(R0)
    prog[10] = 32'h4000_0009;  // ADDI R0,R0,9
    prog[11] = 32'h4380_0001;  // ADDI R7,R0,1
    prog[12] = 32'h0400_0000;  // ADD  R8,R0,R0
    prog[13] = 32'h0CBC_0000;  // SUB  R9,R7,R8
    prog[14] = 32'h2D4B_8000;  // SHR  R10,R9,R7
    prog[15] = 32'h7000_0000;  // HALT

    #2 Clear = 1'b0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_pc", pc_out, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);

    // Request issued, held with run low, then killed by an async reset
    repeat (2) @(negedge Clock);
    Clear = 1'b1; run = 1'b1; ack_wait = 1000;
    #1;
    check("req_issued", mem_req, 1);
    check("req_addr", mem_addr, 0);
    @(negedge Clock);
    run = 1'b0;
    #1;
    check("req_held", mem_req, 1);
    Clear = 1'b0;
    #1;
    check("req_async_drop", mem_req, 0);
    @(negedge Clock);
    Clear = 1'b1;
    repeat (3) @(negedge Clock);
    check("idle_req", mem_req, 0);
    check("idle_pc", pc_out, 0);
    check_reg("idle_r3", 4'd3, 0);

    // Three zero-wait instructions: R3 lands on the 15th edge
    @(negedge Clock);
    ack_wait = 0; run = 1'b1;
    repeat (14) @(negedge Clock);
    #1;
    check("add_r3_early", dbg_data, 0);
    @(negedge Clock);
    #1;
    check("add_r3", dbg_data, 32'd12);
    check("add_pc", pc_out, 32'd3);

    wait_pc(32'd8, 60);
    ack_wait = 1;
    check("addi_lat", 32'(pc_cyc[2] - pc_cyc[1]), 32'd5);
    check("mul_lat", 32'(pc_cyc[7] - pc_cyc[6]), 32'd5);
    check_reg("mul_r1", 4'd1, 32'hFFFF_FFFE);
    check_reg("mul_r2", 4'd2, 32'd3);
    check_reg("mfhi_r4", 4'd4, 32'hFFFF_FFFF);

    wait_pc(32'd11, 80);
    check("st_lat", 32'(pc_cyc[10] - pc_cyc[9]), 32'd8);
    check("ld_lat", 32'(pc_cyc[11] - pc_cyc[10]), 32'd9);
    check("st_addr", wr_addr, 32'h10);
    check("st_data", wr_data, 32'd12);
    check("st_count", 32'(wr_cnt), 32'd1);
    check_reg("mflo_r5", 4'd5, 32'hFFFF_FFFA);
    check_reg("ld_r6", 4'd6, 32'd12);

    wait_pc(32'd16, 100);
    check("halt_early", halted, 0);
    @(negedge Clock);
    #1;
    check("halt_halted", halted, 1);
    check("halt_err", err, 0);
    req_snap = req_cyc;
    check_reg("base_r0", 4'd0, 32'd9);
    check_reg("base_r7", 4'd7, 32'd1);
    check_reg("base_r8", 4'd8, 32'd18);
    check_reg("sub_r9", 4'd9, 32'hFFFF_FFEF);
    check_reg("shr_r10", 4'd10, 32'h7FFF_FFF7);
    repeat (4) @(negedge Clock);
    check("halt_no_req", 32'(req_cyc), 32'(req_snap));
    check("halt_pc", pc_out, 32'd16);
    check("halt_stays", halted, 1);

    // Illegal opcode 31 halts with err; only Clear releases it
    Clear = 1'b0; prog[0] = 32'hF800_0000; run = 1'b1; ack_wait = 0; dbg_sel = 4'd8;
    #1;
    check("clr_halted", halted, 0);
    check("clr_req_run", mem_req, 0);
    check("clr_r8", dbg_data, 0);
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    #1;
    check("ill_halt_early", halted, 0);
    @(negedge Clock);
    #1;
    check("ill_halted", halted, 1);
    check("ill_err", err, 1);
    repeat (3) @(negedge Clock);
    check("ill_err_sticky", err, 1);
    check("ill_pc", pc_out, 32'd1);
    Clear = 1'b0;
    #1;
    check("ill_clr_halted", halted, 0);
    check("ill_clr_err", err, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
